// File: rtl/key_loader_pkg.sv
// Shared types and constants for the serial key loader.
package key_loader_pkg;

  // Width of the unlock key delivered to the locked netlists.
  localparam int KL_KEY_WIDTH_DEFAULT = 16;

  // Loader control states.
  typedef enum logic [1:0] {
    KL_IDLE   = 2'd0,
    KL_SHIFT  = 2'd1,
    KL_CHECK  = 2'd2,
    KL_LOCKED = 2'd3
  } kl_state_e;

  // The counter must reach KEY_WIDTH (the parity slot), so it needs one extra code.
  function automatic int klCountWidth(input int keyWidth);
    return $clog2(keyWidth + 1);
  endfunction

endpackage

// File: rtl/key_shift_reg.sv
// Shadow register for an incoming key frame: data bits are written LSB first at
// the position given by the bit counter, then the trailing parity bit lands in
// its own flop. A running parity over the data bits lets the check be a single XOR.
module key_shift_reg
  import key_loader_pkg::*;
#(
  parameter int KEY_WIDTH = KL_KEY_WIDTH_DEFAULT
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  input  logic                 i_clear,
  input  logic                 i_load,
  input  logic                 i_bit,
  output logic [KEY_WIDTH-1:0] o_shadow,
  output logic                 o_full,
  output logic                 o_parityOk
);

  localparam int CNT_W = klCountWidth(KEY_WIDTH);

  logic [KEY_WIDTH-1:0] r_shadow;
  logic [CNT_W-1:0]     r_count;
  logic                 r_parityBit;
  logic                 r_runParity;
  logic                 w_dataFull;

  // Once every data slot is filled the next accepted bit is the parity bit.
  assign w_dataFull = (r_count == CNT_W'(KEY_WIDTH));

  // Indexed load of data bits, parity capture, and counter/parity bookkeeping.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_shadow    <= '0;
      r_count     <= '0;
      r_parityBit <= 1'b0;
      r_runParity <= 1'b0;
    end else if (i_clear) begin
      r_shadow    <= '0;
      r_count     <= '0;
      r_parityBit <= 1'b0;
      r_runParity <= 1'b0;
    end else if (i_load) begin
      if (w_dataFull) begin
        r_parityBit <= i_bit;
      end else begin
        for (int i = 0; i < KEY_WIDTH; i++) begin
          if (r_count == CNT_W'(i)) begin
            r_shadow[i] <= i_bit;
          end
        end
        r_count     <= r_count + CNT_W'(1);
        r_runParity <= r_runParity ^ i_bit;
      end
    end
  end

  assign o_shadow   = r_shadow;
  assign o_full     = w_dataFull;
  assign o_parityOk = ~(r_runParity ^ r_parityBit);

endmodule

// File: rtl/key_loader.sv
// Serial key programming front end for the locked netlists. Shifts in a key
// frame, checks even parity and commits the key to a held parallel bus. The
// bus only moves on a good commit or on reset, so the netlist never sees a
// half-loaded key.
module key_loader
  import key_loader_pkg::*;
#(
  parameter int KEY_WIDTH    = KL_KEY_WIDTH_DEFAULT,
  parameter int ALLOW_RELOAD = 0
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  input  logic                 i_start,
  input  logic                 i_abort,
  input  logic                 i_sdata,
  input  logic                 i_svalid,
  output logic                 o_sready,
  output logic [KEY_WIDTH-1:0] o_key_out,
  output logic                 o_key_valid,
  output logic                 o_load_err,
  output logic                 o_busy,
  output logic                 o_locked
);

  kl_state_e            r_state;
  logic                 r_sready;
  logic                 r_busy;
  logic                 r_locked;
  logic [KEY_WIDTH-1:0] r_keyOut;
  logic                 r_keyValid;
  logic                 r_loadErr;

  logic                 w_accept;
  logic                 w_clear;
  logic                 w_full;
  logic                 w_parityOk;
  logic [KEY_WIDTH-1:0] w_shadow;

  // r_sready is only ever high in SHIFT, so it doubles as the accept qualifier.
  assign w_accept = r_sready & i_svalid;
  assign w_clear  = (r_state == KL_IDLE) & i_start;

  key_shift_reg #(
    .KEY_WIDTH (KEY_WIDTH)
  ) u_shift (
    .i_clk      (i_clk),
    .i_rst      (i_rst),
    .i_clear    (w_clear),
    .i_load     (w_accept),
    .i_bit      (i_sdata),
    .o_shadow   (w_shadow),
    .o_full     (w_full),
    .o_parityOk (w_parityOk)
  );

  // Control FSM with registered status outputs and the committed key register.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state    <= KL_IDLE;
      r_sready   <= 1'b0;
      r_busy     <= 1'b0;
      r_locked   <= 1'b0;
      r_keyOut   <= '0;
      r_keyValid <= 1'b0;
      r_loadErr  <= 1'b0;
    end else begin
      case (r_state)
        KL_IDLE: begin
          if (i_start) begin
            r_state   <= KL_SHIFT;
            r_sready  <= 1'b1;
            r_busy    <= 1'b1;
            r_loadErr <= 1'b0;
          end
        end
        KL_SHIFT: begin
          if (i_abort) begin
            r_state  <= KL_IDLE;
            r_sready <= 1'b0;
            r_busy   <= 1'b0;
          end else if (w_accept && w_full) begin
            r_state  <= KL_CHECK;
            r_sready <= 1'b0;
          end
        end
        KL_CHECK: begin
          r_busy <= 1'b0;
          if (i_abort) begin
            r_state <= KL_IDLE;
          end else if (w_parityOk) begin
            r_keyOut   <= w_shadow;
            r_keyValid <= 1'b1;
            if (ALLOW_RELOAD != 0) begin
              r_state <= KL_IDLE;
            end else begin
              r_state  <= KL_LOCKED;
              r_locked <= 1'b1;
            end
          end else begin
            r_loadErr <= 1'b1;
            r_state   <= KL_IDLE;
          end
        end
        KL_LOCKED: begin
          r_state <= KL_LOCKED;
        end
        default: begin
          r_state  <= KL_IDLE;
          r_sready <= 1'b0;
          r_busy   <= 1'b0;
        end
      endcase
    end
  end

  assign o_sready    = r_sready;
  assign o_key_out   = r_keyOut;
  assign o_key_valid = r_keyValid;
  assign o_load_err  = r_loadErr;
  assign o_busy      = r_busy;
  assign o_locked    = r_locked;

endmodule

// File: tb/tb_key_loader.sv
// Bench for key_loader: a one-time-load instance and a reload instance share
// the same serial stimulus, and a per-instance scoreboard holds the commit
// result each frame should produce.
module tb_key_loader;

  typedef struct packed {
    logic [15:0] key;
    logic        valid;
    logic        err;
    logic        locked;
  } exp_t;

  logic        clk;
  logic        rst;
  logic        start;
  logic        abort;
  logic        sdata;
  logic        svalid;

  logic        sready0, keyValid0, loadErr0, busy0, locked0;
  logic [15:0] keyOut0;
  logic        sready1, keyValid1, loadErr1, busy1, locked1;
  logic [15:0] keyOut1;

  int   total;
  int   bad;
  exp_t mdl0;
  exp_t mdl1;
  exp_t sb0[$];
  exp_t sb1[$];

  key_loader #(.KEY_WIDTH(16), .ALLOW_RELOAD(0)) dut0 (
    .i_clk(clk), .i_rst(rst), .i_start(start), .i_abort(abort),
    .i_sdata(sdata), .i_svalid(svalid), .o_sready(sready0),
    .o_key_out(keyOut0), .o_key_valid(keyValid0), .o_load_err(loadErr0),
    .o_busy(busy0), .o_locked(locked0)
  );

  key_loader #(.KEY_WIDTH(16), .ALLOW_RELOAD(1)) dut1 (
    .i_clk(clk), .i_rst(rst), .i_start(start), .i_abort(abort),
    .i_sdata(sdata), .i_svalid(svalid), .o_sready(sready1),
    .o_key_out(keyOut1), .o_key_valid(keyValid1), .o_load_err(loadErr1),
    .o_busy(busy1), .o_locked(locked1)
  );

  // Free-running clock, period 10.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Hard stop in case the sequence ever stalls.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: sequence still running at time %0t, required finish", $time);
    $fatal(1);
  end

  // Outcome of a complete frame for one instance, given its current state.
  function automatic exp_t commitModel(input exp_t cur, input logic [15:0] key,
                                       input logic good, input bit reload);
    exp_t nxt;
    nxt = cur;
    if (!cur.locked) begin
      if (good) begin
        nxt.key    = key;
        nxt.valid  = 1'b1;
        nxt.err    = 1'b0;
        nxt.locked = !reload;
      end else begin
        nxt.err = 1'b1;
      end
    end
    return nxt;
  endfunction

  // Sends start plus a 17-bit frame; toggle inserts an idle cycle before every
  // bit after the first, and startAt pulses start in the gap before that bit.
  task automatic sendFrame(input logic [15:0] key, input bit badPar, input bit toggle,
                           input int startAt, input string name);
    logic [16:0] frame;
    logic        act0, act1;
    exp_t        e0, e1;
    frame = {(^key) ^ badPar, key};
    act0  = !mdl0.locked;
    act1  = !mdl1.locked;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    if (act0) mdl0.err = 1'b0;
    if (act1) mdl1.err = 1'b0;
    total++;
    if ({sready0, sready1, loadErr0, loadErr1} !== {act0, act1, mdl0.err, mdl1.err}) begin
      bad++;
      $display("[TB] FAIL %s_start: sready/err got %b want %b", name,
               {sready0, sready1, loadErr0, loadErr1}, {act0, act1, mdl0.err, mdl1.err});
    end
    for (int i = 0; i < 17; i++) begin
      if (toggle && i > 0) begin
        svalid = 1'b0;
        sdata  = ~frame[i];
        start  = (i == startAt);
        @(negedge clk);
        start = 1'b0;
        total++;
        if ({sready0, sready1, keyOut0, keyValid0, keyOut1, keyValid1} !==
            {act0, act1, mdl0.key, mdl0.valid, mdl1.key, mdl1.valid}) begin
          bad++;
          $display("[TB] FAIL %s_gap%0d: got %h want %h", name, i,
                   {sready0, sready1, keyOut0, keyValid0, keyOut1, keyValid1},
                   {act0, act1, mdl0.key, mdl0.valid, mdl1.key, mdl1.valid});
        end
      end
      svalid = 1'b1;
      sdata  = frame[i];
      if (i == 16) begin
        e0 = commitModel(mdl0, key, !badPar, 1'b0);
        e1 = commitModel(mdl1, key, !badPar, 1'b1);
        if (!act0) e0 = mdl0;
        if (!act1) e1 = mdl1;
        sb0.push_back(e0);
        sb1.push_back(e1);
      end
      @(negedge clk);
      total++;
      if ({sready0, sready1, keyOut0, keyValid0, keyOut1, keyValid1} !==
          {act0 & (i < 16), act1 & (i < 16), mdl0.key, mdl0.valid, mdl1.key, mdl1.valid}) begin
        bad++;
        $display("[TB] FAIL %s_bit%0d: got %h want %h", name, i,
                 {sready0, sready1, keyOut0, keyValid0, keyOut1, keyValid1},
                 {act0 & (i < 16), act1 & (i < 16), mdl0.key, mdl0.valid, mdl1.key, mdl1.valid});
      end
    end
    svalid = 1'b0;
    sdata  = 1'b0;
    total++;
    if ({busy0, busy1} !== {act0, act1}) begin
      bad++;
      $display("[TB] FAIL %s_check_busy: got %b want %b", name, {busy0, busy1}, {act0, act1});
    end
    @(negedge clk);
    e0 = sb0.pop_front();
    e1 = sb1.pop_front();
    total++;
    if ({keyOut0, keyValid0, loadErr0, locked0, busy0} !== {e0.key, e0.valid, e0.err, e0.locked, 1'b0}) begin
      bad++;
      $display("[TB] FAIL %s_commit0: got %h want %h", name,
               {keyOut0, keyValid0, loadErr0, locked0, busy0}, {e0.key, e0.valid, e0.err, e0.locked, 1'b0});
    end
    total++;
    if ({keyOut1, keyValid1, loadErr1, locked1, busy1} !== {e1.key, e1.valid, e1.err, e1.locked, 1'b0}) begin
      bad++;
      $display("[TB] FAIL %s_commit1: got %h want %h", name,
               {keyOut1, keyValid1, loadErr1, locked1, busy1}, {e1.key, e1.valid, e1.err, e1.locked, 1'b0});
    end
    mdl0 = e0;
    mdl1 = e1;
  endtask

  // Drives a number of continuous data bits (LSB first) after a start.
  task automatic applyStimulus(input logic [15:0] key, input int nBits);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    if (!mdl0.locked) mdl0.err = 1'b0;
    if (!mdl1.locked) mdl1.err = 1'b0;
    for (int i = 0; i < nBits; i++) begin
      svalid = 1'b1;
      sdata  = key[i];
      @(negedge clk);
    end
    svalid = 1'b0;
    sdata  = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    total++;
    if ({sready0, keyOut0, keyValid0, loadErr0, busy0, locked0,
         sready1, keyOut1, keyValid1, loadErr1, busy1, locked1} !== '0) begin
      bad++;
      $display("[TB] FAIL reset_state: got %h want 0", {sready0, keyOut0, keyValid0, loadErr0,
               busy0, locked0, sready1, keyOut1, keyValid1, loadErr1, busy1, locked1});
    end
    rst  = 1'b0;
    mdl0 = '0;
    mdl1 = '0;
    @(negedge clk);
  endtask

  task automatic test_bad_parity();
    sendFrame(16'hA5C3, 1'b1, 1'b0, -1, "bad_parity");
  endtask

  task automatic test_good_load();
    sendFrame(16'hA5C3, 1'b0, 1'b0, -1, "good_load");
  endtask

  task automatic test_start_locked();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    total++;
    if ({sready0, busy0, locked0, keyOut0} !== {1'b0, 1'b0, 1'b1, 16'hA5C3}) begin
      bad++;
      $display("[TB] FAIL start_locked: got %h want %h", {sready0, busy0, locked0, keyOut0},
               {1'b0, 1'b0, 1'b1, 16'hA5C3});
    end
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    total++;
    if ({busy1, sready1, locked0, keyOut0, keyOut1, keyValid1} !==
        {1'b0, 1'b0, 1'b1, 16'hA5C3, 16'hA5C3, 1'b1}) begin
      bad++;
      $display("[TB] FAIL abort_idle_locked: got %h want %h",
               {busy1, sready1, locked0, keyOut0, keyOut1, keyValid1},
               {1'b0, 1'b0, 1'b1, 16'hA5C3, 16'hA5C3, 1'b1});
    end
  endtask

  task automatic test_reload();
    sendFrame(16'h1234, 1'b0, 1'b0, -1, "load_1234");
    sendFrame(16'hFFFF, 1'b0, 1'b1, 5, "reload_ffff");
  endtask

  task automatic test_abort();
    sendFrame(16'h00FF, 1'b0, 1'b0, -1, "load_00ff");
    applyStimulus(16'h5555, 7);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    total++;
    if ({busy1, sready1, keyOut1, keyValid1, loadErr1} !== {1'b0, 1'b0, 16'h00FF, 1'b1, 1'b0}) begin
      bad++;
      $display("[TB] FAIL abort_shift: got %h want %h", {busy1, sready1, keyOut1, keyValid1, loadErr1},
               {1'b0, 1'b0, 16'h00FF, 1'b1, 1'b0});
    end
    sendFrame(16'h3C5A, 1'b0, 1'b0, -1, "after_abort");
    // Full good frame, then abort lands in CHECK and must beat the commit.
    applyStimulus(16'h0F0F, 16);
    svalid = 1'b1;
    sdata  = ^16'h0F0F;
    @(negedge clk);
    svalid = 1'b0;
    abort  = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    total++;
    if ({busy1, keyOut1, keyValid1, loadErr1} !== {1'b0, 16'h3C5A, 1'b1, 1'b0}) begin
      bad++;
      $display("[TB] FAIL abort_check: got %h want %h", {busy1, keyOut1, keyValid1, loadErr1},
               {1'b0, 16'h3C5A, 1'b1, 1'b0});
    end
  endtask

  task automatic test_async_reset();
    applyStimulus(16'hBEEF, 5);
    #2 rst = 1'b1;
    #1;
    total++;
    if ({sready0, keyOut0, keyValid0, loadErr0, busy0, locked0,
         sready1, keyOut1, keyValid1, loadErr1, busy1, locked1} !== '0) begin
      bad++;
      $display("[TB] FAIL async_reset_shift: got %h want 0", {sready0, keyOut0, keyValid0, loadErr0,
               busy0, locked0, sready1, keyOut1, keyValid1, loadErr1, busy1, locked1});
    end
    @(negedge clk);
    rst  = 1'b0;
    mdl0 = '0;
    mdl1 = '0;
    @(negedge clk);
    sendFrame(16'hC0DE, 1'b0, 1'b0, -1, "relock");
    #2 rst = 1'b1;
    #1;
    total++;
    if ({keyOut0, keyValid0, loadErr0, busy0, locked0, sready0} !== '0) begin
      bad++;
      $display("[TB] FAIL async_reset_locked: got %h want 0",
               {keyOut0, keyValid0, loadErr0, busy0, locked0, sready0});
    end
    @(negedge clk);
    rst = 1'b0;
  endtask

  // Scenario sequence.
  initial begin
    total  = 0;
    bad    = 0;
    start  = 1'b0;
    abort  = 1'b0;
    sdata  = 1'b0;
    svalid = 1'b0;
    rst    = 1'b1;
    mdl0   = '0;
    mdl1   = '0;
    test_reset();
    test_bad_parity();
    test_good_load();
    test_start_locked();
    test_reload();
    test_abort();
    test_async_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
